// File: rtl/demux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : demux_pkg                                                  |
// | Description : Shared constants for the 1-to-8 registered demultiplexer:  |
// |               default data width, channel count and select width.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package demux_pkg;

    localparam int c_width_default = 8;  // default data width per channel
    localparam int c_num_ch        = 8;  // number of output channels
    localparam int c_sel_w         = 3;  // channel select / pointer width

endpackage : demux_pkg
`default_nettype wire

// File: rtl/dec3t8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dec3t8                                                     |
// | Description : 3-to-8 one-hot decoder with enable. Output is all-zero     |
// |               when disabled, otherwise bit i_sel is set.                 |
// | Ports       : i_en     - decoder enable                                  |
// |               i_sel    - 3-bit index                                     |
// |               o_onehot - 8-bit one-hot result                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dec3t8
    import demux_pkg::*;
(
    input  logic                i_en,
    input  logic [c_sel_w-1:0]  i_sel,
    output logic [c_num_ch-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule : dec3t8
`default_nettype wire

// File: rtl/demux1t8_8_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : demux1t8_8_reg                                             |
// | Description : Registered 1-to-8 demultiplexer. Each load writes d into   |
// |               one of eight WIDTH-bit channel registers; strobe reports   |
// |               which channel changed on the last edge.                    |
// |               Optional auto-increment mode (macro DEMUX_AUTOINC_EN)      |
// |               walks an internal pointer 0..7 and pulses frame_done after |
// |               channel 7 is written.                                      |
// | Ports       : clk, rst (sync, active-high), load, s, d                   |
// |               auto, ptr    - only with DEMUX_AUTOINC_EN                  |
// |               O0..O7       - registered channel outputs                  |
// |               strobe       - one-hot write indication                    |
// |               frame_done   - end-of-frame pulse (0 without the macro)    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module demux1t8_8_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = c_width_default
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [c_sel_w-1:0]  s,
    input  logic [WIDTH-1:0]    d,
`ifdef DEMUX_AUTOINC_EN
    input  logic                auto,
    output logic [c_sel_w-1:0]  ptr,
`endif
    output logic [WIDTH-1:0]    O0,
    output logic [WIDTH-1:0]    O1,
    output logic [WIDTH-1:0]    O2,
    output logic [WIDTH-1:0]    O3,
    output logic [WIDTH-1:0]    O4,
    output logic [WIDTH-1:0]    O5,
    output logic [WIDTH-1:0]    O6,
    output logic [WIDTH-1:0]    O7,
    output logic [c_num_ch-1:0] strobe,
    output logic                frame_done
);

    logic [c_sel_w-1:0]  w_target;
    logic [c_num_ch-1:0] w_we;
    logic [c_num_ch-1:0] r_strobe;
    logic [WIDTH-1:0]    r_ch [c_num_ch];

`ifdef DEMUX_AUTOINC_EN
    logic [c_sel_w-1:0] r_ptr;
    logic               r_frame_done;

    assign w_target = auto ? r_ptr : s;

    // Pointer only moves on auto loads; switching modes leaves it in place
    // so the next auto load resumes where the frame left off.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= load && auto && (r_ptr == c_sel_w'(c_num_ch - 1));
            if (load && auto) begin
                r_ptr <= r_ptr + c_sel_w'(1);
            end
        end
    end

    assign ptr        = r_ptr;
    assign frame_done = r_frame_done;
`else
    assign w_target   = s;
    assign frame_done = 1'b0;
`endif

    // The decoder output doubles as per-channel write enable and as the
    // next value of strobe.
    dec3t8 u_dec (
        .i_en     (load),
        .i_sel    (w_target),
        .o_onehot (w_we)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_strobe <= '0;
        end else begin
            r_strobe <= w_we;
        end
    end

    generate
        for (genvar gi = 0; gi < c_num_ch; gi++) begin : g_ch
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ch[gi] <= '0;
                end else if (w_we[gi]) begin
                    r_ch[gi] <= d;
                end
            end
        end
    endgenerate

    assign strobe = r_strobe;
    assign O0     = r_ch[0];
    assign O1     = r_ch[1];
    assign O2     = r_ch[2];
    assign O3     = r_ch[3];
    assign O4     = r_ch[4];
    assign O5     = r_ch[5];
    assign O6     = r_ch[6];
    assign O7     = r_ch[7];

endmodule : demux1t8_8_reg
`default_nettype wire

// File: doc/demux1t8_8_reg.md
DEMUX1T8_8_REG -- requirements
Module: demux1t8_8_reg

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width of input and of each output channel.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: load  input  1  write strobe; one channel write per cycle when high.
REQ-005 SHALL have port: s  input  3  target channel select in addressed mode.
REQ-006 SHALL have port: d  input  WIDTH  data to write.
REQ-007 SHALL have port: auto  input  1  1 = auto-increment mode, 0 = addressed mode; present only with DEMUX_AUTOINC_EN.
REQ-008 SHALL have ports: O0..O7  output  WIDTH each  registered channel outputs.
REQ-009 SHALL have port: strobe  output  8  one-hot write indication, bit i = O_i updated last edge.
REQ-010 SHALL have port: ptr  output  3  auto-increment pointer; present only with DEMUX_AUTOINC_EN.
REQ-011 SHALL have port: frame_done  output  1  one-cycle pulse after channel 7 written in auto mode.

Function
REQ-012 SHALL compute target = (auto ? ptr : s) at each rising edge where load=1.
REQ-013 SHALL write d to O_target at that edge; latency one cycle (d visible on O_target the cycle after load).
REQ-014 SHALL hold all non-target outputs, and all outputs when load=0.
REQ-015 SHALL drive strobe = one-hot(target) for exactly the cycle after a load, else 8'h00.
REQ-016 SHALL increment ptr by 1 modulo 8 on each load with auto=1; 7 wraps to 0.
REQ-017 SHALL leave ptr unchanged on loads with auto=0 and while load=0.
REQ-018 SHALL pulse frame_done high for one cycle following a load with auto=1 and ptr=7, else low.
REQ-019 SHALL apply mode change on auto between cycles without resetting ptr; next auto load uses current ptr.
REQ-020 SHALL accept back-to-back loads every cycle with no stall; consecutive loads to same channel keep last value.

Reset
REQ-021 SHALL on rst=1 at a rising edge clear O0..O7 to 0, strobe to 0, ptr to 0, frame_done to 0.
REQ-022 SHALL give rst priority over load in the same cycle; the write is discarded.
REQ-023 SHALL abandon a partial auto frame on reset; next frame starts at channel 0.

Configuration
REQ-024 SHALL compile auto-increment logic only when macro DEMUX_AUTOINC_EN is defined.
REQ-025 SHALL with DEMUX_AUTOINC_EN: auto and ptr ports exist, REQ-012..REQ-019 apply fully.
REQ-026 SHALL without DEMUX_AUTOINC_EN: auto and ptr ports absent, target = s always, frame_done tied 0.

Structure
REQ-027 SHALL place WIDTH default, channel count (8), and select width (3) constants in shared package demux_pkg.
REQ-028 SHALL instantiate one sub-module dec3t8 (3-to-8 one-hot decoder with enable) producing write enables and strobe next-state.
REQ-029 SHALL hold each channel in its own WIDTH-bit register with enable from dec3t8.

Verification
REQ-030 SHALL cover: rst=1 with load=1, d=8'hFF -> next cycle O0..O7=0, strobe=0, ptr=0, frame_done=0.
REQ-031 SHALL cover: addressed, s=0..7 on 8 consecutive cycles, d=8'h00,8'h11..8'h77 -> O_i=i*8'h11, strobe=8'h01,8'h02..8'h80 in order.
REQ-032 SHALL cover: auto=1, 8 consecutive loads d=8'hA0..8'hA7 -> O_i=8'hA0+i, ptr returns to 0, frame_done high only the cycle after the eighth load.
REQ-033 SHALL cover: load=0 while s and d toggle for 10 cycles -> outputs unchanged, strobe=0.
REQ-034 SHALL cover: auto frame, rst after 3 loads -> ptr=0, all outputs 0; following load d=8'h5A lands on O0.
REQ-035 SHALL cover: loopback, O0..O7 driven into MUX8T1_8 inputs, s swept 0..7 every 50 ns -> mux output equals byte written to channel s.
